// File: rtl/if_stream_packer.sv
// rtl/if_stream_packer.sv - tags raw IF words with row flags and packs PAR_WRITE entries per FIFO write
module if_stream_packer #(
    parameter int DATA_WIDTH = 16,
    parameter int PAR_WRITE  = 4,
    parameter int LEN_W      = 8
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 start,
    input  logic [LEN_W-1:0]                     row_len,
    input  logic [LEN_W-1:0]                     num_rows,
    input  logic [DATA_WIDTH-1:0]                in_data,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    output logic [PAR_WRITE*(DATA_WIDTH+2)-1:0]  IF_din,
    output logic                                 IF_wen,
    input  logic                                 IF_full,
    output logic                                 busy,
    output logic                                 done
);
    localparam int EW = DATA_WIDTH + 2;
    localparam int CW = $clog2(PAR_WRITE + 1);

    typedef enum logic [1:0] {IDLE, PACK, FLUSH, DONE} state_t;

    state_t                  state;
    logic [CW-1:0]           lane_cnt;
    logic [LEN_W-1:0]        col_cnt;
    logic [LEN_W-1:0]        row_cnt;
    logic [LEN_W-1:0]        row_len_q;
    logic [LEN_W-1:0]        num_rows_q;
    logic [PAR_WRITE*EW-1:0] lanes;

    logic group_full;
    logic col_last;
    logic row_last;
    logic accept;

    assign group_full = (lane_cnt == CW'(PAR_WRITE));
    assign col_last   = (col_cnt == row_len_q - LEN_W'(1));
    assign row_last   = (row_cnt == num_rows_q - LEN_W'(1));
    assign in_ready   = (state == PACK) && !group_full;
    assign accept     = in_ready && in_valid;

    // Write strobe follows IF_full combinationally so a full FIFO simply holds the group.
    assign IF_wen = !IF_full && (((state == PACK) && group_full) ||
                                 ((state == FLUSH) && (lane_cnt != '0)));
    assign IF_din = lanes;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            lane_cnt   <= '0;
            col_cnt    <= '0;
            row_cnt    <= '0;
            row_len_q  <= '0;
            num_rows_q <= '0;
            lanes      <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        row_len_q  <= row_len;
                        num_rows_q <= num_rows;
                        col_cnt    <= '0;
                        row_cnt    <= '0;
                        lane_cnt   <= '0;
                        lanes      <= '0;
                        busy       <= 1'b1;
                        if ((row_len == '0) || (num_rows == '0)) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= PACK;
                        end
                    end
                end
                PACK: begin
                    if (accept) begin
                        for (int i = 0; i < PAR_WRITE; i++) begin
                            if (lane_cnt == CW'(i))
                                lanes[i*EW +: EW] <= {(col_cnt == '0), col_last, in_data};
                        end
                        lane_cnt <= lane_cnt + CW'(1);
                        if (col_last) begin
                            col_cnt <= '0;
                            row_cnt <= row_cnt + LEN_W'(1);
                            if (row_last)
                                state <= FLUSH;
                        end else begin
                            col_cnt <= col_cnt + LEN_W'(1);
                        end
                    end else if (IF_wen) begin
                        // Clearing on write leaves zero entries behind for the flush padding.
                        lanes    <= '0;
                        lane_cnt <= '0;
                    end
                end
                FLUSH: begin
                    if (lane_cnt == '0) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else if (!IF_full) begin
                        lanes    <= '0;
                        lane_cnt <= '0;
                        state    <= DONE;
                        done     <= 1'b1;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_if_stream_packer.sv
// tb/tb_if_stream_packer.sv - table-driven scoreboard bench for if_stream_packer
module tb_if_stream_packer;
    localparam int DW = 16;
    localparam int PW = 4;
    localparam int LW = 8;
    localparam int EW = DW + 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [LW-1:0]     row_len;
    logic [LW-1:0]     num_rows;
    logic [DW-1:0]     in_data;
    logic              in_valid;
    logic              in_ready;
    logic [PW*EW-1:0]  IF_din;
    logic              IF_wen;
    logic              IF_full;
    logic              busy;
    logic              done;

    if_stream_packer #(.DATA_WIDTH(DW), .PAR_WRITE(PW), .LEN_W(LW)) dut (
        .clk(clk), .rst(rst), .start(start), .row_len(row_len), .num_rows(num_rows),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .IF_din(IF_din), .IF_wen(IF_wen), .IF_full(IF_full), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int rl;
        int nr;
        int stall;
        int exp_writes;
    } vec_t;

    vec_t             vecs[8];
    logic [PW*EW-1:0] exp_q[$];
    int               checks = 0;
    int               errors = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference packing: word k of the frame carries data k+1.
    task automatic push_expected(input int rl, input int nr);
        logic [PW*EW-1:0] w;
        logic [EW-1:0]    e;
        int               lane;
        int               col;
        w    = '0;
        lane = 0;
        for (int k = 0; k < rl * nr; k++) begin
            col = k % rl;
            e = {(col == 0), (col == rl - 1), DW'(k + 1)};
            w[lane*EW +: EW] = e;
            lane++;
            if (lane == PW) begin
                exp_q.push_back(w);
                w    = '0;
                lane = 0;
            end
        end
        if (lane != 0) exp_q.push_back(w);
    endtask

    task automatic run_frame(input int rl, input int nr, input int stall,
                             output int writes, output int done_cycle,
                             output logic [PW*EW-1:0] first_din,
                             output logic [PW*EW-1:0] last_din);
        int               nxt;
        int               n;
        int               stall_left;
        bit               fin;
        bit               have_hold;
        logic [PW*EW-1:0] hold;
        logic [PW*EW-1:0] exp;
        push_expected(rl, nr);
        writes     = 0;
        done_cycle = -1;
        first_din  = '0;
        last_din   = '0;
        @(negedge clk);
        start    = 1'b1;
        row_len  = LW'(rl);
        num_rows = LW'(nr);
        @(negedge clk);
        start    = 1'b0;
        row_len  = LW'(7);
        num_rows = LW'(7);
        nxt        = 1;
        n          = rl * nr;
        stall_left = stall;
        fin        = 1'b0;
        have_hold  = 1'b0;
        hold       = '0;
        for (int cyc = 0; cyc < 2000 && !fin; cyc++) begin
            in_valid = (nxt <= n);
            in_data  = DW'(nxt);
            IF_full  = (stall_left > 0);
            start    = (cyc == 2);
            row_len  = LW'(2);
            #1;
            if (busy && !in_ready && !done && IF_full) begin
                chk("stall_wen", IF_wen, 0);
                chk("stall_ready", in_ready, 0);
                if (have_hold) chk("stall_din_stable", IF_din, hold);
                hold      = IF_din;
                have_hold = 1'b1;
                stall_left--;
            end
            if (in_valid && in_ready) nxt++;
            if (IF_wen) begin
                if (exp_q.size() == 0) begin
                    chk("extra_write", 1, 0);
                end else begin
                    exp = exp_q.pop_front();
                    chk("write_din", IF_din, exp);
                end
                if (writes == 0) first_din = IF_din;
                last_din = IF_din;
                writes++;
            end
            if (done) begin
                done_cycle = cyc;
                fin        = 1'b1;
            end
            @(negedge clk);
        end
        start    = 1'b0;
        in_valid = 1'b0;
        IF_full  = 1'b0;
        chk("frame_finished", fin, 1);
        #1;
        chk("done_one_cycle", done, 0);
        chk("busy_after_done", busy, 0);
        chk("queue_drained", exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        int               writes;
        int               dcyc;
        int               w_exp;
        logic [PW*EW-1:0] fd;
        logic [PW*EW-1:0] ld;
        logic [PW*EW-1:0] t1_w0;
        logic [PW*EW-1:0] t1_w1;
        logic [PW*EW-1:0] t4_w0;

        t1_w0 = {18'h20004, 18'h10003, 18'h00002, 18'h20001};
        t1_w1 = {18'h00000, 18'h00000, 18'h10006, 18'h00005};
        t4_w0 = {18'h00000, 18'h30003, 18'h30002, 18'h30001};

        vecs[0] = '{rl: 3, nr: 2, stall: 0, exp_writes: 2};
        vecs[1] = '{rl: 4, nr: 1, stall: 0, exp_writes: 1};
        vecs[2] = '{rl: 3, nr: 2, stall: 5, exp_writes: 2};
        vecs[3] = '{rl: 1, nr: 3, stall: 0, exp_writes: 1};
        vecs[4] = '{rl: 3, nr: 0, stall: 0, exp_writes: 0};
        vecs[5] = '{rl: 5, nr: 3, stall: 0, exp_writes: 4};
        vecs[6] = '{rl: 2, nr: 4, stall: 3, exp_writes: 2};
        vecs[7] = '{rl: 0, nr: 2, stall: 0, exp_writes: 0};

        rst = 1'b1; start = 1'b0; row_len = '0; num_rows = '0;
        in_data = '0; in_valid = 1'b0; IF_full = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_in_ready", in_ready, 0);
        chk("reset_wen", IF_wen, 0);
        chk("reset_din", IF_din, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            run_frame(vecs[i].rl, vecs[i].nr, vecs[i].stall, writes, dcyc, fd, ld);
            chk("write_count", writes, vecs[i].exp_writes);
            w_exp = vecs[i].rl * vecs[i].nr + vecs[i].exp_writes + vecs[i].stall;
            chk("done_latency", dcyc, w_exp);
            if (i == 0 || i == 2) begin
                chk("t1_write0", fd, t1_w0);
                chk("t1_write1", ld, t1_w1);
            end
            if (i == 3) chk("t4_write0", fd, t4_w0);
        end

        // Reset after two accepted words of a frame, then replay the same frame.
        @(negedge clk);
        start = 1'b1; row_len = LW'(3); num_rows = LW'(2);
        @(negedge clk);
        start = 1'b0; in_valid = 1'b1; in_data = DW'(1);
        #1;
        chk("t6_ready_w1", in_ready, 1);
        @(negedge clk);
        in_data = DW'(2);
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("t6_no_wen", IF_wen, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("t6_ready_reset", in_ready, 0);
        chk("t6_busy_reset", busy, 0);
        chk("t6_din_reset", IF_din, 0);
        chk("t6_wen_reset", IF_wen, 0);
        run_frame(3, 2, 0, writes, dcyc, fd, ld);
        chk("t6_writes", writes, 2);
        chk("t6_write0", fd, t1_w0);
        chk("t6_write1", ld, t1_w1);
        chk("t6_done_latency", dcyc, 8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
